// File: rtl/push_pop_sequencer_pkg.sv
// push_pop_sequencer_pkg: register selects, sequencer states and list helpers.
package push_pop_sequencer_pkg;
  localparam logic [4:0] SEL_R0 = 5'd0;
  localparam logic [4:0] SEL_R1 = 5'd1;
  localparam logic [4:0] SEL_R2 = 5'd2;
  localparam logic [4:0] SEL_R3 = 5'd3;
  localparam logic [4:0] SEL_R4 = 5'd4;
  localparam logic [4:0] SEL_R5 = 5'd5;
  localparam logic [4:0] SEL_R6 = 5'd6;
  localparam logic [4:0] SEL_R7 = 5'd7;
  localparam logic [4:0] SEL_SP = 5'd13;
  localparam logic [4:0] SEL_LR = 5'd14;
  localparam logic [4:0] SEL_PC = 5'd15;
  localparam logic [4:0] SEL_TMP1 = 5'd16;
  localparam logic [4:0] SEL_NONE = 5'b11101;
  localparam int WORD_BYTES = 4;
  typedef enum logic [2:0] {S_IDLE, S_PUSH_XFER, S_POP_XFER, S_POP_DRAIN, S_FINISH} state_t;
  function automatic logic [3:0] popcount9(input logic [8:0] l);
    popcount9 = '0;
    for (int i = 0; i < 9; i++) popcount9 = popcount9 + 4'(l[i]);
  endfunction
endpackage

// File: rtl/push_pop_sequencer_reglist_prio_enc.sv
// reglist_prio_enc: lowest set bit of a 9-bit register list, plus the list with it removed.
module reglist_prio_enc (
  input  logic [8:0] i_list,
  output logic [3:0] o_idx,
  output logic       o_valid,
  output logic [8:0] o_rest
);
  always_comb begin
    o_idx = '0;
    for (int i = 8; i >= 0; i--) o_idx = i_list[i] ? 4'(i) : o_idx;
    o_valid = |i_list;
    o_rest = i_list & (i_list - 9'd1);
  end
endmodule

// File: rtl/push_pop_sequencer.sv
// push_pop_sequencer: multi-cycle Thumb PUSH {rlist,LR} / POP {rlist,PC} sequencer
// driving register-file ports, data-memory strobes and the final SP update.
module push_pop_sequencer
  import push_pop_sequencer_pkg::*;
#(
  parameter int WIDE = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic            i_is_pop,
  input  logic [8:0]      i_reg_list,
  input  logic [WIDE-1:0] i_sp_in,
  input  logic [WIDE-1:0] i_mem_rdata,
  output logic            o_busy,
  output logic            o_stall,
  output logic            o_done,
  output logic [4:0]      o_rd_sel,
  output logic [4:0]      o_wr_sel,
  output logic            o_wr_en,
  output logic [WIDE-1:0] o_wr_data,
  output logic [WIDE-1:0] o_mem_addr,
  output logic            o_mem_wr_en,
  output logic            o_mem_rd_en,
  output logic            o_sp_wr_en,
  output logic [WIDE-1:0] o_sp_new
);
  state_t r_state, w_next;
  logic [8:0] r_list;
  logic r_pop;
  logic [WIDE-1:0] r_sp, r_ptr;
  logic [3:0] r_n;
  logic [1:0] r_drain;
  logic [RD_LATENCY-1:0] r_pv;
  logic [4:0] r_psel [RD_LATENCY];
  logic [3:0] w_idx, w_n_in;
  logic w_valid, w_last, w_xfer, w_issue, w_start;
  logic [8:0] w_rest;
  logic [4:0] w_sel;
  logic [WIDE-1:0] w_bytes, w_bytes_in;
  reglist_prio_enc u_enc (.i_list(r_list), .o_idx(w_idx), .o_valid(w_valid), .o_rest(w_rest));
  assign w_n_in = popcount9(i_reg_list);
  assign w_bytes_in = WIDE'(w_n_in) * WIDE'(WORD_BYTES);
  assign w_bytes = WIDE'(r_n) * WIDE'(WORD_BYTES);
  // Bit 8 of the list names LR for a push and PC for a pop.
  assign w_sel = w_idx[3] ? (r_pop ? SEL_PC : SEL_LR) : {2'b00, w_idx[2:0]};
  assign w_last = w_rest == '0;
  assign w_start = r_state == S_IDLE && i_start;
  assign w_xfer = r_state == S_PUSH_XFER || r_state == S_POP_XFER;
  assign w_issue = r_state == S_POP_XFER && w_valid;
  always_ff @(posedge clk) r_state <= reset ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = !i_start ? S_IDLE : w_n_in == '0 ? S_FINISH : i_is_pop ? S_POP_XFER : S_PUSH_XFER;
      S_PUSH_XFER: w_next = w_last ? S_FINISH : S_PUSH_XFER;
      S_POP_XFER: w_next = w_last ? S_POP_DRAIN : S_POP_XFER;
      S_POP_DRAIN: w_next = r_drain == '0 ? S_FINISH : S_POP_DRAIN;
      default: w_next = S_IDLE;
    endcase
    o_busy = r_state != S_IDLE;
    o_stall = o_busy || w_start;
    o_done = r_state == S_FINISH;
    o_sp_wr_en = o_done && r_n != '0;
    o_sp_new = o_done ? (r_pop ? r_sp + w_bytes : r_sp - w_bytes) : '0;
    o_mem_wr_en = r_state == S_PUSH_XFER && w_valid;
    o_mem_rd_en = w_issue;
    o_mem_addr = w_xfer ? r_ptr : '0;
    o_rd_sel = o_mem_wr_en ? w_sel : SEL_NONE;
    o_wr_en = r_pv[RD_LATENCY-1];
    o_wr_sel = o_wr_en ? r_psel[RD_LATENCY-1] : SEL_NONE;
    // PC loads drop the Thumb interworking bit.
    o_wr_data = o_wr_en ? i_mem_rdata & ~WIDE'(o_wr_sel == SEL_PC) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_list <= '0;
      r_pop <= 1'b0;
      r_sp <= '0;
      r_ptr <= '0;
      r_n <= '0;
      r_drain <= '0;
      r_pv <= '0;
    end else begin
      if (w_start) begin
        r_list <= i_reg_list;
        r_pop <= i_is_pop;
        r_sp <= i_sp_in;
        r_n <= w_n_in;
        r_ptr <= i_is_pop ? i_sp_in : i_sp_in - w_bytes_in;
      end else if (w_xfer) begin
        r_list <= w_rest;
        r_ptr <= r_ptr + WIDE'(WORD_BYTES);
      end
      r_drain <= r_state == S_POP_DRAIN ? r_drain - 2'd1 : 2'(RD_LATENCY - 1);
      r_pv[0] <= w_issue;
      for (int i = 1; i < RD_LATENCY; i++) r_pv[i] <= r_pv[i-1];
    end
  end
  always_ff @(posedge clk) begin
    r_psel[0] <= w_sel;
    for (int i = 1; i < RD_LATENCY; i++) r_psel[i] <= r_psel[i-1];
  end
endmodule
